// File: rtl/ram_param_clr_if.sv
// Bus bundle for ram_param_clr: port A read/write, port B read-only, sweep busy flag.
interface ram_param_clr_if #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 8
);
    logic [AWIDTH-1:0] address;
    logic [WIDTH-1:0]  in;
    logic              load;
    logic [WIDTH-1:0]  out;
    logic [AWIDTH-1:0] rd_address;
    logic [WIDTH-1:0]  rd_out;
    logic              busy;

    modport master (
        output address, in, load, rd_address,
        input  out, rd_out, busy
    );

    modport slave (
        input  address, in, load, rd_address,
        output out, rd_out, busy
    );
endinterface

// File: rtl/ram_param_clr.sv
// Parametrised single-clock RAM with a debug read port and a post-reset clear sweep.
// One write port shared by the sweep and port A; two read ports, read-before-write.
module ram_param_clr #(
    parameter int               WIDTH     = 16,
    parameter int               AWIDTH    = 8,
    parameter int               SYNC_READ = 0,
    parameter int               CLEAR_EN  = 1,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    ram_param_clr_if.slave   bus
);
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {SWEEP, READY} state_t;
    localparam state_t RESET_STATE = (CLEAR_EN != 0) ? SWEEP : READY;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q, busy_d;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            clr_ptr_q <= '0;
            busy_q    <= (CLEAR_EN != 0);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // The sweep owns the write port; port A loads are dropped, not queued.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        we        = 1'b0;
        waddr     = bus.address;
        wdata     = bus.in;
        case (state_q)
            SWEEP: begin
                we    = 1'b1;
                waddr = clr_ptr_q;
                wdata = CLEAR_VAL;
                if (clr_ptr_q == AWIDTH'(DEPTH - 1)) begin
                    state_d = READY;
                end else begin
                    clr_ptr_d = clr_ptr_q + AWIDTH'(1);
                end
            end
            READY: begin
                we = bus.load;
            end
            default: begin
                state_d = READY;
            end
        endcase
        busy_d = (state_d == SWEEP);
    end

    assign bus.busy = busy_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    logic [1:0][AWIDTH-1:0] raddr;
    logic [1:0][WIDTH-1:0]  rdata;

    assign raddr[0]   = bus.address;
    assign raddr[1]   = bus.rd_address;
    assign bus.out    = rdata[0];
    assign bus.rd_out = rdata[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            if (SYNC_READ != 0) begin : g_sync
                logic [WIDTH-1:0] rdata_q;
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        rdata_q <= '0;
                    end else begin
                        rdata_q <= mem[raddr[gi]];
                    end
                end
                assign rdata[gi] = rdata_q;
            end else begin : g_comb
                assign rdata[gi] = mem[raddr[gi]];
            end
        end
    endgenerate
endmodule

// File: tb/tb_ram_param_clr.sv
// Drives a combinational-read and a registered-read instance with the same stimulus
// and checks both against an array model of the memory and clear sweep.
module tb_ram_param_clr;
    localparam logic [15:0] CLR = 16'h0000;

    logic        clk;
    logic        reset;
    logic [7:0]  address, rd_address;
    logic [15:0] in_v;
    logic        load;
    bit          inc_mode;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    logic [15:0] mem_m [256];
    bit          busy_m;
    int          sweep_idx;

    ram_param_clr_if #(.WIDTH(16), .AWIDTH(8)) if0 ();
    ram_param_clr_if #(.WIDTH(16), .AWIDTH(8)) if1 ();

    assign if0.address    = address;
    assign if0.in         = inc_mode ? 16'(if0.out + 16'd1) : in_v;
    assign if0.load       = load;
    assign if0.rd_address = rd_address;
    assign if1.address    = address;
    assign if1.in         = in_v;
    assign if1.load       = load;
    assign if1.rd_address = rd_address;

    ram_param_clr #(.WIDTH(16), .AWIDTH(8), .SYNC_READ(0), .CLEAR_EN(1), .CLEAR_VAL(CLR))
        dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    ram_param_clr #(.WIDTH(16), .AWIDTH(8), .SYNC_READ(1), .CLEAR_EN(1), .CLEAR_VAL(CLR))
        dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    function automatic bit readable(input logic [7:0] a);
        return !busy_m || (int'(a) < sweep_idx);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy0", {15'b0, if0.busy}, 16'd1);
        check("rst_busy1", {15'b0, if1.busy}, 16'd1);
        check("rst_out1", if1.out, 16'h0000);
        check("rst_rd1", if1.rd_out, 16'h0000);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        busy_m    = 1'b1;
        sweep_idx = 0;
        $display("reset released at %0t", $time);
    endtask

    // One clock: combinational reads checked before the edge, registered reads after.
    task automatic cycle();
        logic [15:0] exp_out, exp_rd;
        bit ok_a, ok_b;
        #1;
        ok_a = readable(address);
        ok_b = readable(rd_address);
        if (ok_a) check("comb_out", if0.out, mem_m[address]);
        if (ok_b) check("comb_rd", if0.rd_out, mem_m[rd_address]);
        exp_out = mem_m[address];
        exp_rd  = mem_m[rd_address];
        @(posedge clk);
        if (busy_m) begin
            mem_m[sweep_idx] = CLR;
            sweep_idx++;
            if (sweep_idx == 256) busy_m = 1'b0;
        end else if (load) begin
            mem_m[address] = in_v;
        end
        #1;
        if (ok_a) check("sync_out", if1.out, exp_out);
        if (ok_b) check("sync_rd", if1.rd_out, exp_rd);
        check("busy0", {15'b0, if0.busy}, {15'b0, busy_m});
        check("busy1", {15'b0, if1.busy}, {15'b0, busy_m});
        $display("cyc %0d a=%h ld=%b in=%h rda=%h out0=%h out1=%h rd0=%h rd1=%h busy=%b",
                 n_cyc, address, load, in_v, rd_address, if0.out, if1.out,
                 if0.rd_out, if1.rd_out, if0.busy);
        n_cyc++;
    endtask

    task automatic rand_inputs(input int amax);
        address    = 8'($urandom_range(0, amax));
        rd_address = 8'($urandom_range(0, amax));
        load       = 1'($urandom);
        in_v       = 16'($urandom);
    endtask

    task automatic read_all();
        for (int i = 0; i < 256; i++) begin
            address    = 8'(i);
            rd_address = 8'(255 - i);
            load       = 1'b0;
            cycle();
        end
    endtask

    initial begin
        reset = 1'b1; address = '0; rd_address = '0; in_v = '0; load = 1'b0; inc_mode = 1'b0;
        busy_m = 1'b1; sweep_idx = 0;
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;

        // First sweep with random loads that must be dropped, including 0xFFFF@3 at cycle 10.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rand_inputs(255);
            if (i == 10) begin
                address = 8'd3; in_v = 16'hFFFF; load = 1'b1;
            end
            cycle();
            if (i == 254) check("t1_busy_last", {15'b0, if1.busy}, 16'd1);
        end
        check("t1_busy_done", {15'b0, if0.busy}, 16'd0);
        read_all();
        address = 8'd3; load = 1'b0;
        cycle();
        check("t4_mem3", if0.out, CLR);

        // Increment through combinational feedback: one read-before-write step.
        address = 8'd5; in_v = 16'h0041; load = 1'b1;
        cycle();
        inc_mode = 1'b1; in_v = 16'h0042;
        cycle();
        check("t2_out", if0.out, 16'h0042);
        inc_mode = 1'b0; load = 1'b0;
        cycle();
        check("t2_hold", if1.out, 16'h0042);

        // Registered read returns the old word on a same-address write edge.
        address = 8'd7; in_v = 16'hBEEF; load = 1'b1;
        cycle();
        in_v = 16'h1234;
        cycle();
        check("t3_old", if1.out, 16'hBEEF);
        load = 1'b0;
        cycle();
        check("t3_new", if1.out, 16'h1234);

        // Port B collision with a port A write.
        address = 8'd9; rd_address = 8'd9; in_v = 16'h5555; load = 1'b1;
        cycle();
        in_v = 16'h00AA;
        cycle();
        check("t6_old", if1.rd_out, 16'h5555);
        load = 1'b0;
        cycle();
        check("t6_new1", if1.rd_out, 16'h00AA);
        check("t6_new0", if0.rd_out, 16'h00AA);

        // Random traffic over a small window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(15);
            cycle();
        end

        // Fill every word with non-clear data, then abort a sweep at cycle 100.
        for (int i = 0; i < 256; i++) begin
            address = 8'(i); rd_address = 8'($urandom); in_v = 16'($urandom_range(1, 16'hFFFF));
            load = 1'b1;
            cycle();
        end
        do_reset();
        for (int i = 0; i < 100; i++) begin
            rand_inputs(255);
            cycle();
        end
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rand_inputs(255);
            cycle();
            if (i == 254) check("t5_busy_last", {15'b0, if0.busy}, 16'd1);
        end
        check("t5_busy_done", {15'b0, if1.busy}, 16'd0);
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
